// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman game sequencer.
package hangman_pkg;

  typedef enum logic [2:0] {
    PH_SETUP  = 3'd0,
    PH_ARMED  = 3'd1,
    PH_PLAY   = 3'd2,
    PH_EVAL   = 3'd3,
    PH_REPORT = 3'd4,
    PH_WIN    = 3'd5,
    PH_LOSE   = 3'd6
  } phase_t;

  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_Z     = 8'h5A;
  localparam logic [7:0] ASCII_BLANK = 8'h5F;

  function automatic logic is_letter(input logic [7:0] c);
    return (c >= ASCII_A) && (c <= ASCII_Z);
  endfunction

endpackage

// File: rtl/hangman_game_ctrl_letter_match.sv
// Combinational per-position compare of the secret word against one guess.
module letter_match #(
  parameter int WORD_LEN = 5
) (
  input  logic [WORD_LEN-1:0][7:0] word,
  input  logic [7:0]               guess,
  output logic [WORD_LEN-1:0]      hit
);

  always_comb begin
    hit = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      hit[i] = (word[i] == guess);
    end
  end

endmodule

// File: rtl/hangman_game_ctrl.sv
// Hangman game sequencer: word setup, guess judging, tx hand-off, win/lose.
// tx handshake: a byte moves on any clk edge where tx_valid=1 and tx_busy=0;
// tx_valid/tx_data hold steady until that edge.
module hangman_game_ctrl
  import hangman_pkg::*;
#(
  parameter int WORD_LEN     = 5,
  parameter int MAX_MISTAKES = 6
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic                ready,
  input  logic [7:0]          data,
  input  logic                toggle_state,
  input  logic                game_end,
  input  logic                tx_busy,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  output logic [WORD_LEN-1:0] mask,
  output logic [2:0]          mistakes,
  output logic [2:0]          phase,
  output logic                win,
  output logic                lose,
  output logic                dup
);

  localparam logic [3:0] LAST_IDX = 4'(WORD_LEN - 1);
  localparam logic [2:0] MAX_MIS  = 3'(MAX_MISTAKES);

  phase_t                   state;
  logic [WORD_LEN-1:0][7:0] word;
  logic [3:0]               idx;
  logic [7:0]               guess;
  logic [25:0]              used;
  logic [WORD_LEN-1:0]      hit;
  logic [7:0]               guess_off;
  logic [4:0]               guess_idx;
  logic                     letter_ok;

  assign letter_ok = ready && is_letter(data);
  assign guess_off = guess - ASCII_A;
  assign guess_idx = guess_off[4:0];
  assign phase     = state;

  letter_match #(.WORD_LEN(WORD_LEN)) u_match (
    .word  (word),
    .guess (guess),
    .hit   (hit)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= PH_SETUP;
      word     <= '0;
      idx      <= '0;
      guess    <= '0;
      used     <= '0;
      mask     <= '0;
      mistakes <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      win      <= 1'b0;
      lose     <= 1'b0;
      dup      <= 1'b0;
    end else begin
      dup <= 1'b0;
      if (game_end) begin
        state    <= PH_SETUP;
        word     <= '0;
        idx      <= '0;
        used     <= '0;
        mask     <= '0;
        mistakes <= '0;
        tx_valid <= 1'b0;
        win      <= 1'b0;
        lose     <= 1'b0;
      end else begin
        case (state)
          PH_SETUP: if (letter_ok) begin
            word[idx] <= data;
            idx       <= idx + 4'd1;
            if (idx == LAST_IDX) state <= PH_ARMED;
          end
          PH_ARMED: if (toggle_state) state <= PH_PLAY;
          PH_PLAY: if (letter_ok) begin
            guess <= data;
            state <= PH_EVAL;
          end
          PH_EVAL: begin
            if (used[guess_idx]) begin
              dup   <= 1'b1;
              state <= PH_PLAY;
            end else begin
              used[guess_idx] <= 1'b1;
              if (|hit) mask <= mask | hit;
              else      mistakes <= mistakes + 3'd1;
              tx_valid <= 1'b1;
              tx_data  <= guess;
              state    <= PH_REPORT;
            end
          end
          PH_REPORT: if (!tx_busy) begin
            tx_valid <= 1'b0;
            if (&mask) begin
              win   <= 1'b1;
              state <= PH_WIN;
            end else if (mistakes == MAX_MIS) begin
              lose  <= 1'b1;
              state <= PH_LOSE;
            end else begin
              state <= PH_PLAY;
            end
          end
          PH_WIN, PH_LOSE: if (toggle_state) begin
            state    <= PH_SETUP;
            word     <= '0;
            idx      <= '0;
            used     <= '0;
            mask     <= '0;
            mistakes <= '0;
            win      <= 1'b0;
            lose     <= 1'b0;
          end
          default: state <= PH_SETUP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hangman_game_ctrl.sv
// Directed bench for hangman_game_ctrl with a tx-byte scoreboard.
module tb_hangman_game_ctrl;

  localparam int P_SETUP  = 0;
  localparam int P_ARMED  = 1;
  localparam int P_PLAY   = 2;
  localparam int P_EVAL   = 3;
  localparam int P_REPORT = 4;
  localparam int P_WIN    = 5;
  localparam int P_LOSE   = 6;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] data = 8'h00;
  logic       toggle_state = 1'b0;
  logic       game_end = 1'b0;
  logic       tx_busy = 1'b0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [4:0] mask;
  logic [2:0] mistakes;
  logic [2:0] phase;
  logic       win, lose, dup;

  int total = 0;
  int bad   = 0;
  int busy_mode = 0;
  logic [7:0] exp_q[$];

  hangman_game_ctrl #(.WORD_LEN(5), .MAX_MISTAKES(6)) dut (
    .clk          (clk),
    .nRst         (nRst),
    .ready        (ready),
    .data         (data),
    .toggle_state (toggle_state),
    .game_end     (game_end),
    .tx_busy      (tx_busy),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .mask         (mask),
    .mistakes     (mistakes),
    .phase        (phase),
    .win          (win),
    .lose         (lose),
    .dup          (dup)
  );

  // clock / reset
  always #5 clk = ~clk;

  // tx_busy driver: 0 = idle, 1 = stuck busy, 2 = toggling
  always @(posedge clk) begin
    #2;
    case (busy_mode)
      1:       tx_busy = 1'b1;
      2:       tx_busy = ~tx_busy;
      default: tx_busy = 1'b0;
    endcase
  end

  // monitor: a transfer happens at the next posedge when valid & ~busy
  always @(negedge clk) begin
    if (nRst && !game_end && tx_valid && !tx_busy) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL tx_unexpected got=%h want=none", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          bad++;
          $display("FAIL tx_byte got=%h want=%h", tx_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic send_letter(input logic [7:0] b);
    ready = 1'b1;
    data  = b;
    tick();
    ready = 1'b0;
    data  = 8'h00;
  endtask

  task automatic pulse_toggle();
    toggle_state = 1'b1;
    tick();
    toggle_state = 1'b0;
  endtask

  task automatic wait_phase(input string name, input int p, input int budget);
    int n;
    n = 0;
    while (int'(phase) != p && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(phase), 32'(p));
  endtask

  // guess that is expected to be accepted and transmitted
  task automatic guess(input logic [7:0] b);
    exp_q.push_back(b);
    send_letter(b);
    tick();
    total++;
    if (int'(phase) != P_REPORT) begin
      bad++;
      $display("FAIL guess_report got=%0d want=%0d", phase, P_REPORT);
    end
    for (int i = 0; i < 20 && int'(phase) == P_REPORT; i++) tick();
  endtask

  task automatic load_hello();
    send_letter("H");
    send_letter(8'h5F);
    pulse_toggle();
    send_letter("E");
    send_letter("L");
    send_letter("L");
    send_letter("O");
    check("armed", 32'(phase), P_ARMED);
    send_letter("Q");
    pulse_toggle();
    check("play_after_toggle", 32'(phase), P_PLAY);
  endtask

  initial begin
    #3;
    check("rst_phase", 32'(phase), P_SETUP);
    check("rst_txv", 32'(tx_valid), 0);
    tick();
    nRst = 1'b1;
    tick();

    // reset while stuck in REPORT
    load_hello();
    busy_mode = 1;
    send_letter("L");
    tick(); tick(); tick();
    check("held_report", 32'(phase), P_REPORT);
    check("held_txv", 32'(tx_valid), 1);
    check("held_txd", 32'(tx_data), 32'h4C);
    nRst = 1'b0;
    #1;
    check("rst2_vec", {tx_valid, tx_data, 3'b0, mask, 5'b0, mistakes, 5'b0, phase, win, lose, dup}, 32'h0);
    busy_mode = 0;
    tick();
    nRst = 1'b1;
    tick();

    // first guess, then a duplicate
    load_hello();
    guess("L");
    check("L_mask", 32'(mask), 32'b01100);
    check("L_mis", 32'(mistakes), 0);
    check("L_phase", 32'(phase), P_PLAY);
    send_letter("L");
    tick();
    check("dup_pulse", 32'(dup), 1);
    check("dup_phase", 32'(phase), P_PLAY);
    check("dup_txv", 32'(tx_valid), 0);
    check("dup_mis", 32'(mistakes), 0);
    tick();
    check("dup_clear", 32'(dup), 0);

    // H with ready pulses dropped in EVAL and in a busy REPORT
    exp_q.push_back("H");
    send_letter("H");
    ready = 1'b1; data = "Z";
    busy_mode = 1;
    tick();
    data = "Y";
    tick(); tick();
    check("H_hold_phase", 32'(phase), P_REPORT);
    check("H_hold_txd", 32'(tx_data), 32'h48);
    ready = 1'b0; data = 8'h00;
    busy_mode = 0;
    wait_phase("H_back_play", P_PLAY, 10);
    check("H_mask", 32'(mask), 32'b01101);
    check("drop_no_mis", 32'(mistakes), 0);
    guess("E");
    send_letter(8'h5F);
    check("blank_ignored", 32'(phase), P_PLAY);
    guess("O");
    check("win_phase", 32'(phase), P_WIN);
    check("win_flag", 32'({win, lose}), 32'b10);
    check("win_mask", 32'(mask), 32'b11111);
    pulse_toggle();
    check("win_to_setup", 32'(phase), P_SETUP);
    check("win_clear", 32'({mask, win}), 0);

    // six misses with a toggling transmitter
    load_hello();
    busy_mode = 2;
    guess("A");
    guess("B");
    guess("C");
    check("mis_3", 32'(mistakes), 3);
    guess("D");
    guess("F");
    check("not_lost_5", 32'(lose), 0);
    guess("G");
    busy_mode = 0;
    check("lose_phase", 32'(phase), P_LOSE);
    check("lose_flag", 32'({win, lose}), 32'b01);
    check("lose_mis", 32'(mistakes), 6);
    pulse_toggle();
    check("lose_to_setup", 32'({mistakes, lose}), 0);

    // game_end concurrent with a guess
    load_hello();
    ready = 1'b1; data = "A"; game_end = 1'b1;
    tick();
    ready = 1'b0; data = 8'h00; game_end = 1'b0;
    check("ge_phase", 32'(phase), P_SETUP);
    check("ge_txv", 32'(tx_valid), 0);
    tick();
    check("ge_still", 32'({phase, tx_valid, mistakes}), 0);

    tick(); tick(); tick();
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hangman_game_ctrl.md
# hangman_game_ctrl

Game sequencer downstream of the keypad letter-entry FSM and upstream of the UART/radio transmitter. Collects the secret word in a setup phase, then judges each submitted guess: updates the revealed-letter mask and mistake count, rejects repeated guesses, and forwards every accepted guess to the transmitter over a valid/busy handshake. Declares win/lose and returns to setup on new-game or end-of-game events.

## Interface
- `WORD_LEN`, 5: secret word length in letters (2..8).
- `MAX_MISTAKES`, 6: wrong guesses that end the game (1..7).

- `clk`  in  1  clock
- `nRst`  in  1  reset, asynchronous, active-low
- `ready`  in  1  one-cycle pulse: letter submitted; `data` valid this cycle
- `data`  in  8  ASCII letter from keypad FSM; 0x5F (`_`) = blank
- `toggle_state`  in  1  word-submit / new-round request
- `game_end`  in  1  abort; highest priority
- `tx_busy`  in  1  transmitter cannot accept a byte
- `tx_valid`  out  1  byte offered to transmitter
- `tx_data`  out  8  offered byte (guessed letter)
- `mask`  out  WORD_LEN  bit i = position i revealed
- `mistakes`  out  3  wrong-guess count
- `phase`  out  3  current state encoding
- `win`, `lose`  out  1 each  terminal flags, held while in terminal state
- `dup`  out  1  one-cycle pulse: guess already used, no penalty

## Operation
- States: SETUP, ARMED, PLAY, EVAL, REPORT, WIN, LOSE.
- Valid letter = `data` in 0x41..0x5A. Other `ready` data (incl. 0x5F) ignored in all states.
- SETUP: valid letter on `ready` → `word[idx]`, idx+1. When idx reaches WORD_LEN → ARMED. `toggle_state` ignored in SETUP.
- ARMED: further letters ignored. `toggle_state` → PLAY; mask, mistakes, used[25:0] already zero.
- PLAY: valid letter on `ready` → latch `guess`, → EVAL. `toggle_state` ignored.
- EVAL: if `used[guess-'A']`, pulse `dup` and → PLAY; mask, mistakes, tx unchanged. Otherwise set used bit; hit vector = per-position `word[i]==guess`. If hit nonzero, `mask |= hit`; else `mistakes+1`. → REPORT with `tx_valid`=1, `tx_data`=guess.
- REPORT: transfer occurs on the edge where `tx_valid & ~tx_busy`; `tx_valid` deasserts after that edge. Next state chosen at the same edge: mask all ones → WIN; else mistakes==MAX_MISTAKES → LOSE; else PLAY. `ready` pulses during EVAL/REPORT are dropped.
- WIN/LOSE: `win`/`lose` high. `toggle_state` → SETUP; clears word, idx, mask, mistakes, used, flags.
- `game_end` in any state → SETUP with the same clear and `tx_valid`=0; overrides a concurrent `ready`, `toggle_state`, or transfer.
- Duplicate letters in the secret word are legal; one guess reveals all matching positions.

## Timing
- Reset values: `tx_valid` 0, `tx_data` 0x00, `mask` 0, `mistakes` 0, `phase` SETUP, `win` 0, `lose` 0, `dup` 0, idx 0, used 0.
- All outputs registered.
- `ready` sampled at edge k in PLAY → EVAL after k. Mask/mistakes/`tx_valid` or `dup` update at edge k+1.
- With `tx_busy`=0: transfer at edge k+2; next `ready` is accepted from edge k+3.
- `tx_busy` high holds REPORT and `tx_data` stable indefinitely.
- SETUP → ARMED at the edge storing letter WORD_LEN. ARMED → PLAY one edge after `toggle_state`.
- `mistakes` saturates at MAX_MISTAKES because LOSE is entered first.

## Structure
- `hangman_pkg`: phase enum (SETUP=0 … LOSE=6), ASCII constants `ASCII_A`=0x41, `ASCII_Z`=0x5A, `ASCII_BLANK`=0x5F.
- Sub-module `letter_match`: purely combinational. Inputs: word array and guess. Outputs: WORD_LEN hit vector. Instantiated once.
- Word store, used vector, and counters stay in the top FSM.

## Test plan
- Reset mid-REPORT with `tx_busy`=1 → all outputs at reset values, `phase`=SETUP.
- Word "HELLO", `toggle_state`, guess 'L' → `mask`=5'b01100 (bit0=H), `mistakes`=0, one tx byte 0x4C.
- Guesses 'L','L' → second guess gives `dup` pulse, no mistake, no tx, `phase` back to PLAY after one cycle.
- Word "HELLO", six wrong letters 'A','B','C','D','F','G' with `tx_busy` toggling → six bytes in order, `lose`=1 after sixth transfer, `mistakes`=6.
- Guesses H,E,L,O → `win`=1 after 'O' transfer. Then `toggle_state` → SETUP, mask 0. 0x5F and `ready` during REPORT are ignored.
- `game_end` concurrent with `ready` in PLAY → SETUP, no EVAL, `tx_valid` stays 0.
